shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a four-stage shift/rotate unit.
// A granted operation walks through stages of 1, 2, 4 and 8 bits, then waits in DONE for the consumer.
module shift_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req0_cnt,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic        lastGrant_q, lastGrant_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        sign_q, sign_d;
  logic        grant0, grant1;
  logic [3:0]  stageAmt;
  logic [15:0] stepped;

  // Bit-wise source selection; 4-bit index arithmetic gives the rotate wrap for free.
  function automatic logic [15:0] stepShift(input logic [15:0] w, input logic [1:0] op,
                                            input logic [3:0] amt, input logic fill);
    logic [15:0] r;
    logic [3:0]  li;
    logic [3:0]  ri;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      li = 4'(i) - amt;
      ri = 4'(i) + amt;
      case (op)
        2'b00:   r[i] = w[li];
        2'b01:   r[i] = (i >= int'(amt)) ? w[li] : 1'b0;
        2'b10:   r[i] = w[ri];
        default: r[i] = (i + int'(amt) <= 15) ? w[ri] : fill;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (FIXED_PRI) begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      grant0 = lastGrant_q;
      grant1 = ~lastGrant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;

  assign stageAmt = 4'd1 << stage_q;
  assign stepped  = stepShift(work_q, op_q, stageAmt, sign_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= 2'd0;
      lastGrant_q <= 1'b1;
      work_q      <= 16'h0000;
      cnt_q       <= 4'd0;
      op_q        <= 2'd0;
      id_q        <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      lastGrant_q <= lastGrant_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      sign_q      <= sign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    lastGrant_d = lastGrant_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    id_d        = id_q;
    sign_d      = sign_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          work_d      = grant1 ? req1_data : req0_data;
          cnt_d       = grant1 ? req1_cnt  : req0_cnt;
          op_d        = grant1 ? req1_op   : req0_op;
          sign_d      = grant1 ? req1_data[15] : req0_data[15];
          id_d        = grant1;
          lastGrant_d = grant1;
          stage_d     = 2'd0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q[stage_q]) work_d = stepped;
        stage_d = stage_q + 2'd1;
        if (stage_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_valid ? work_q : 16'h0000;
  assign rsp_id    = rsp_valid & id_q;
  assign busy      = (state_q != IDLE);

endmodule
